// File: rtl/imageproc_cmd_engine.sv
// Command front-end: valid/ack intake into a small FIFO, in-order execution against a
// config register file, busy/refresh/error status. Optional macro: CMDENG_PARITY_EN.
module imageproc_cmd_engine #(
  parameter int CMD_W          = 4,
  parameter int DATA_W         = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int NUM_REGS       = 16,
  parameter int REFRESH_CYCLES = 8,
  localparam int ADDR_W        = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_valid,
`ifdef CMDENG_PARITY_EN
  input  logic              cmd_parity,
`endif
  output logic              cmd_ack,
  output logic              busy,
  output logic              refresh,
  output logic              error,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              dbg_state
);

  // Handshake: the source holds cmd/cmd_data with cmd_valid until it sees cmd_ack.
  // A command is taken on an edge where cmd_valid=1, the queue has room and cmd_ack
  // is low; cmd_ack pulses the following cycle, so a held command is taken only once.

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int RC_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int ENTRY_W = CMD_W + DATA_W;

  localparam logic [CMD_W-1:0]  OP_NOP     = CMD_W'(0);
  localparam logic [CMD_W-1:0]  OP_SETADDR = CMD_W'(1);
  localparam logic [CMD_W-1:0]  OP_WRITE   = CMD_W'(2);
  localparam logic [CMD_W-1:0]  OP_REFRESH = CMD_W'(3);
  localparam logic [CMD_W-1:0]  OP_CLRERR  = CMD_W'(4);
  localparam logic [DATA_W:0]   NUM_REGS_X = (DATA_W + 1)'(NUM_REGS);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_REFRESH = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [RC_W-1:0]    rcnt_q, rcnt_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic               err_q, err_d;
  logic               ack_q, busy_q, busy_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ENTRY_W-1:0] fifo_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  regs_q [NUM_REGS];

  logic               accept, par_ok, push, pop, wr_en;
  logic [CMD_W-1:0]   head_cmd;
  logic [DATA_W-1:0]  head_data;

`ifdef CMDENG_PARITY_EN
  assign par_ok = (cmd_parity == ^{cmd, cmd_data});
`else
  assign par_ok = 1'b1;
`endif

  assign accept    = cmd_valid && (count_q != FULL_CNT) && !ack_q;
  assign push      = accept && par_ok;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign head_cmd  = fifo_q[rd_ptr_q][ENTRY_W-1:DATA_W];
  assign head_data = fifo_q[rd_ptr_q][DATA_W-1:0];

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          case (head_cmd)
            OP_NOP: begin end
            OP_SETADDR: begin
              if ({1'b0, head_data} >= NUM_REGS_X) err_d = 1'b1;
              else                                 ptr_d = head_data[ADDR_W-1:0];
            end
            OP_WRITE: begin
              wr_en = 1'b1;
              ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_W'(1);
            end
            OP_REFRESH: begin
              state_d = S_REFRESH;
              rcnt_d  = RC_W'(REFRESH_CYCLES - 1);
            end
            OP_CLRERR: err_d = 1'b0;
            default:   err_d = 1'b1;
          endcase
        end
      end
      S_REFRESH: begin
        if (rcnt_q == '0) state_d = S_IDLE;
        else              rcnt_d  = rcnt_q - RC_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // A dropped (bad parity) command outranks a CLR_ERR executing on the same edge.
    if (accept && !par_ok) err_d = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    busy_d = (count_d != '0) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rcnt_q   <= '0;
      ptr_q    <= '0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      ack_q   <= accept;
      busy_q  <= busy_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {cmd, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[ptr_q] <= head_data;
    end
  end

  assign rd_data   = regs_q[rd_addr];
  assign cmd_ack   = ack_q;
  assign busy      = busy_q;
  assign refresh   = (state_q == S_REFRESH);
  assign error     = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imageproc_cmd_engine.sv
// Bench for imageproc_cmd_engine: directed scenarios plus random commands, all checked
// every cycle against a queue-based model of the command engine.
module tb_imageproc_cmd_engine;
  localparam int CMD_W  = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int NREGS  = 16;
  localparam int RC     = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_valid;
  logic              cmd_ack, busy, refresh, error, dbg_state;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
`ifdef CMDENG_PARITY_EN
  logic              cmd_parity;
  bit                bad_par;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  imageproc_cmd_engine #(
    .CMD_W(CMD_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH),
    .NUM_REGS(NREGS), .REFRESH_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
`ifdef CMDENG_PARITY_EN
    .cmd_parity(cmd_parity),
`endif
    .cmd_ack(cmd_ack), .busy(busy), .refresh(refresh), .error(error),
    .rd_addr(rd_addr), .rd_data(rd_data), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [CMD_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0]       m_regs [NREGS];
  int                      m_ptr, m_ref_left;
  bit                      m_err, m_ack, m_busy, chk_en;

  initial begin : model
    bit                      acc, pbad;
    logic [CMD_W+DATA_W-1:0] e;
    int                      op, d;
    chk_en = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_ptr = 0; m_ref_left = 0; m_err = 0; m_ack = 0; m_busy = 0;
        chk_en = 1'b1;
      end else begin
        acc  = cmd_valid && (exp_q.size() < DEPTH) && !m_ack;
        pbad = 1'b0;
`ifdef CMDENG_PARITY_EN
        pbad = (cmd_parity != ($countones({cmd, cmd_data}) % 2 == 1));
`endif
        if (m_ref_left > 0) begin
          m_ref_left--;
        end else if (exp_q.size() != 0) begin
          e  = exp_q.pop_front();
          op = int'(e[CMD_W+DATA_W-1:DATA_W]);
          d  = int'(e[DATA_W-1:0]);
          case (op)
            0: begin end
            1: if (d >= NREGS) m_err = 1'b1; else m_ptr = d;
            2: begin m_regs[m_ptr] = d[DATA_W-1:0]; m_ptr = (m_ptr + 1) % NREGS; end
            3: m_ref_left = RC;
            4: m_err = 1'b0;
            default: m_err = 1'b1;
          endcase
        end
        if (acc) begin
          if (pbad) m_err = 1'b1;
          else      exp_q.push_back({cmd, cmd_data});
        end
        m_ack  = acc;
        m_busy = (exp_q.size() != 0) || (m_ref_left > 0);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cmd_ack", 32'(cmd_ack), 32'(m_ack));
        check("busy",    32'(busy),    32'(m_busy));
        check("refresh", 32'(refresh), 32'(m_ref_left > 0));
        check("error",   32'(error),   32'(m_err));
        check("rd_data", 32'(rd_data), 32'(m_regs[rd_addr]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] d);
    int t;
    cmd = c; cmd_data = d; cmd_valid = 1'b1;
`ifdef CMDENG_PARITY_EN
    cmd_parity = (^{c, d}) ^ bad_par;
`endif
    t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (!cmd_ack && t < 100);
    check("ack_seen", 32'(cmd_ack), 32'd1);
    cmd_valid = 1'b0;
`ifdef CMDENG_PARITY_EN
    bad_par = 1'b0;
`endif
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk); t++;
    end while (busy !== 1'b0 && t < 300);
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic check_reg(input string name, input int a, input logic [DATA_W-1:0] v);
    rd_addr = a[ADDR_W-1:0];
    @(negedge clk);
    check(name, 32'(rd_data), 32'(v));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int hi;
    rst = 1'b1; cmd = '0; cmd_data = '0; cmd_valid = 1'b0; rd_addr = '0;
`ifdef CMDENG_PARITY_EN
    cmd_parity = 1'b0; bad_par = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_refresh", 32'(refresh), 32'd0);

    // Pointer wrap: 15 then 0
    send(4'd1, 8'd15); send(4'd2, 8'hA5); send(4'd2, 8'h3C);
    wait_idle();
    check_reg("wrap_reg15", 15, 8'hA5);
    check_reg("wrap_reg0", 0, 8'h3C);

    // Refresh length
    send(4'd3, 8'd0);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (refresh === 1'b1) hi++;
    end
    check("refresh_len", 32'(hi), 32'd8);
    check("refresh_busy_low", 32'(busy), 32'd0);

    // Queue fill while a refresh runs
    send(4'd1, 8'd2);
    send(4'd3, 8'd0); send(4'd3, 8'd0);
    send(4'd2, 8'h11); send(4'd2, 8'h22); send(4'd2, 8'h33); send(4'd2, 8'h44);
    wait_idle();
    check_reg("full_reg2", 2, 8'h11);
    check_reg("full_reg3", 3, 8'h22);
    check_reg("full_reg4", 4, 8'h33);
    check_reg("full_reg5", 5, 8'h44);
    check_reg("full_reg6", 6, 8'h00);

    // Sticky error and bad SET_ADDR
    send(4'd9, 8'd0); wait_idle();
    check("illegal_err", 32'(error), 32'd1);
    send(4'd0, 8'd0); send(4'd0, 8'd0); send(4'd0, 8'd0); wait_idle();
    check("err_sticky", 32'(error), 32'd1);
    send(4'd4, 8'd0); wait_idle();
    check("err_cleared", 32'(error), 32'd0);
    send(4'd1, 8'd8); send(4'd1, 8'd20); wait_idle();
    check("setaddr_range_err", 32'(error), 32'd1);
    send(4'd4, 8'd0); send(4'd2, 8'h77); wait_idle();
    check_reg("ptr_kept_reg8", 8, 8'h77);
    check("err_after_clr", 32'(error), 32'd0);

    // Reset mid-refresh
    send(4'd9, 8'd0); send(4'd3, 8'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_refresh", 32'(refresh), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_ack", 32'(cmd_ack), 32'd0);
    for (int a = 0; a < NREGS; a++) check_reg("midrst_reg", a, 8'h00);
    @(posedge clk); #1 rst = 1'b0;

`ifdef CMDENG_PARITY_EN
    send(4'd1, 8'd7);
    bad_par = 1'b1; send(4'd2, 8'h5A); wait_idle();
    check_reg("par_bad_reg7", 7, 8'h00);
    check("par_bad_err", 32'(error), 32'd1);
    send(4'd4, 8'd0); send(4'd2, 8'h5A); wait_idle();
    check_reg("par_good_reg7", 7, 8'h5A);
    check("par_good_err", 32'(error), 32'd0);
`endif

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      int sel;
      logic [CMD_W-1:0]  c;
      logic [DATA_W-1:0] d;
      sel = int'($urandom_range(0, 99));
      if (sel < 10)      c = 4'd0;
      else if (sel < 30) c = 4'd1;
      else if (sel < 75) c = 4'd2;
      else if (sel < 82) c = 4'd3;
      else if (sel < 90) c = 4'd4;
      else               c = 4'($urandom_range(5, 15));
      d = (c == 4'd1) ? 8'($urandom_range(0, 22)) : 8'($urandom_range(0, 255));
`ifdef CMDENG_PARITY_EN
      bad_par = ($urandom_range(0, 7) == 0);
`endif
      rd_addr = 4'($urandom_range(0, NREGS - 1));
      send(c, d);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();
    for (int a = 0; a < NREGS; a++) check_reg("final_reg", a, m_regs[a]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
